pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state changes on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 icache_stall  in  1  instruction fetch not complete this cycle.
REQ-004 dcache_stall  in  1  MEM-stage data access not complete this cycle.
REQ-005 EX_DMRd, EX_RD  in  1, 5  load in EX and its destination register.
REQ-006 ID_RS, ID_RT  in  5, 5  source registers of the instruction in ID.
REQ-007 ID_UseRS, ID_UseRT  in  1, 1  the ID instruction reads RS / RT in ID.
REQ-008 EX_start  in  1  multi-cycle mul/div in EX requests start.
REQ-009 MEM_Exception, MEM_eret_flush  in  1, 1  exception / ERET committing in MEM.
REQ-010 PC_Wr, IF_IDWr, ID_EX_WrEn, EX_MEM_WrEn  out  1 each  stage write enables.
REQ-011 IF_Flush, ID_Flush, EX_Flush, MEM_Flush  out  1 each  stage flushes; flush overrides write enable downstream.
REQ-012 NPC_Sel  out  2  next-PC source: 00 normal, 10 exception vector, 11 EPC.
REQ-013 div_busy  out  1  multi-cycle unit occupied (registered).

Function
REQ-014 FSM states: RUN, DIV, REDIR. The FSM SHALL leave any state only on the conditions in REQ-015 to REQ-021.
REQ-015 Priority in a cycle, high to low: redirect (exception/ERET with dcache_stall=0), dcache_stall, DIV, load-use, icache_stall, normal.
REQ-016 Normal (RUN, no condition): all WrEn=1, all flushes=0, NPC_Sel=00.
REQ-017 Load-use when EX_DMRd=1 and EX_RD!=0 and ((ID_UseRS and ID_RS==EX_RD) or (ID_UseRT and ID_RT==EX_RD)): PC_Wr=0, IF_IDWr=0, ID_Flush=1, EX_MEM_WrEn=1, for exactly one cycle per hazard.
REQ-018 icache_stall alone: PC_Wr=0, IF_IDWr=0, IF_Flush=1, ID_EX_WrEn=1, EX_MEM_WrEn=1.
REQ-019 dcache_stall: all WrEn=0, all flushes=0; FSM state and div counter frozen except as in REQ-020.
REQ-020 RUN with EX_start=1 and no higher-priority condition -> DIV; 6-bit counter loads DIV_LAT-1 (DIV_LAT=32). In DIV: PC_Wr=IF_IDWr=ID_EX_WrEn=EX_MEM_WrEn=0, EX_Flush=1 (bubble into MEM); counter decrements each non-dcache-stall cycle; EX_start ignored.
REQ-021 DIV with counter==0 and dcache_stall=0: completion cycle behaves as RUN normal (EX_MEM_WrEn=1, EX_Flush=0, ID_EX_WrEn=1); next state RUN. Counter reaching 0 during dcache_stall holds at 0.
REQ-022 Redirect (MEM_Exception or MEM_eret_flush, dcache_stall=0): IF_Flush=ID_Flush=EX_Flush=MEM_Flush=1; NPC_Sel=10 if MEM_Exception else 11; any DIV aborted (counter cleared, div_busy=0 next cycle).
REQ-023 Redirect with icache_stall=0: PC_Wr=1 this cycle, next state RUN. With icache_stall=1: PC_Wr=0, NPC_Sel latched, next state REDIR.
REQ-024 REDIR: IF_Flush=ID_Flush=EX_Flush=1, MEM_Flush=0, PC_Wr=0, NPC_Sel=latched value; when icache_stall=0, PC_Wr=1, next state RUN. A new redirect in REDIR re-latches NPC_Sel.
REQ-025 Simultaneous MEM_Exception and MEM_eret_flush: exception wins (NPC_Sel=10).
REQ-026 div_busy=1 exactly while state==DIV.

Reset
REQ-027 On rst=0 at posedge clk: state=RUN, counter=0, latched NPC_Sel=00, div_busy=0; outputs decode as RUN normal on the following cycle regardless of inputs; reset mid-DIV or mid-REDIR abandons the operation.

Structure
REQ-028 State encoding, NPC_Sel codes and DIV_LAT SHALL live in the shared macro/package file with existing pipeline constants.
REQ-029 One sub-module, hazard_detect (combinational load-use compare, REQ-017); FSM, counter and output decode stay in pipe_ctrl.

Verification
REQ-030 EX_DMRd=1, EX_RD=5, ID_RS=5, ID_UseRS=1 -> one cycle PC_Wr=0, IF_IDWr=0, ID_Flush=1; next cycle normal. With EX_RD=0 -> no stall.
REQ-031 EX_start=1 in RUN -> div_busy=1 for 32 cycles, EX_Flush=1 and ID_EX_WrEn=0 throughout; 33rd cycle all WrEn=1, state RUN.
REQ-032 DIV, 3 dcache_stall cycles mid-count -> completion delayed by exactly 3 cycles; all WrEn=0 during the stall cycles.
REQ-033 MEM_Exception=1 with icache_stall=1 for 4 cycles -> MEM_Flush=1 on the first cycle only, PC_Wr=0 for 4 cycles, then PC_Wr=1 with NPC_Sel=10.
REQ-034 MEM_eret_flush=1 during DIV at count 10 -> all four flushes=1, NPC_Sel=11, PC_Wr=1, div_busy=0 next cycle.
REQ-035 rst=0 asserted during REDIR -> next cycle state RUN, NPC_Sel=00, all WrEn=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline constants: register-index width, control FSM encoding,
// next-PC source codes, multi-cycle divide latency and stage-control bundle.
package pipe_ctrl_pkg;

  localparam int REG_W     = 5;
  localparam int DIV_LAT   = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_CNT_W-1:0] DIV_CNT_LOAD = DIV_CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DIV   = 2'b01,
    ST_REDIR = 2'b10
  } pipe_state_e;

  localparam logic [1:0] NPC_NORMAL  = 2'b00;
  localparam logic [1:0] NPC_EXC_VEC = 2'b10;
  localparam logic [1:0] NPC_EPC     = 2'b11;

  // Stage write enables, flushes and next-PC select driven as one bundle.
  typedef struct packed {
    logic       pc_wr;
    logic       if_id_wr;
    logic       id_ex_wr;
    logic       ex_mem_wr;
    logic       if_flush;
    logic       id_flush;
    logic       ex_flush;
    logic       mem_flush;
    logic [1:0] npc_sel;
  } ctrl_t;

  // Everything advances, nothing flushed.
  localparam ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0, NPC_NORMAL};
  // Whole pipeline frozen while the data cache is busy.
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, NPC_NORMAL};
  // Divide in EX: front end and EX hold, bubble pushed into MEM.
  localparam ctrl_t CTRL_DIV    = '{1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 1'b0, NPC_NORMAL};

  // Exception beats ERET when both commit in the same cycle.
  function automatic logic [1:0] redirect_npc(input logic exc);
    return exc ? NPC_EXC_VEC : NPC_EPC;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_dmrd_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  output logic             load_use_o
);

  logic rs_hit_s;
  logic rt_hit_s;

  // Register zero is never a real dependency, so it cannot cause a stall.
  always_comb begin
    rs_hit_s   = id_use_rs_i && (id_rs_i == ex_rd_i);
    rt_hit_s   = id_use_rt_i && (id_rt_i == ex_rd_i);
    load_use_o = ex_dmrd_i && (ex_rd_i != {REG_W{1'b0}}) && (rs_hit_s || rt_hit_s);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush/redirect decode plus the RUN/DIV/REDIR FSM
// that sequences multi-cycle divides and icache-stalled redirects.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             EX_DMRd,
  input  logic [REG_W-1:0] EX_RD,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_UseRS,
  input  logic             ID_UseRT,
  input  logic             EX_start,
  input  logic             MEM_Exception,
  input  logic             MEM_eret_flush,
  output logic             PC_Wr,
  output logic             IF_IDWr,
  output logic             ID_EX_WrEn,
  output logic             EX_MEM_WrEn,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EX_Flush,
  output logic             MEM_Flush,
  output logic [1:0]       NPC_Sel,
  output logic             div_busy
);

  pipe_state_e          state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           npc_lat_q, npc_lat_d;
  logic                 div_busy_q;
  logic                 post_rst_q;

  logic                 load_use_s;
  logic                 redirect_s;
  ctrl_t                run_ctrl_s;
  ctrl_t                ctrl_s;

  hazard_detect u_hazard_detect (
    .ex_dmrd_i   (EX_DMRd),
    .ex_rd_i     (EX_RD),
    .id_rs_i     (ID_RS),
    .id_rt_i     (ID_RT),
    .id_use_rs_i (ID_UseRS),
    .id_use_rt_i (ID_UseRT),
    .load_use_o  (load_use_s)
  );

  assign redirect_s = MEM_Exception || MEM_eret_flush;

  // FSM state, divide counter, latched redirect target and busy flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= {DIV_CNT_W{1'b0}};
      npc_lat_q  <= NPC_NORMAL;
      div_busy_q <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      npc_lat_q  <= npc_lat_d;
      div_busy_q <= (state_d == ST_DIV);
      post_rst_q <= 1'b0;
    end
  end

  // Low-priority RUN decode: load-use bubble beats an instruction-fetch stall.
  always_comb begin
    run_ctrl_s = CTRL_NORMAL;
    if (load_use_s) begin
      run_ctrl_s.pc_wr    = 1'b0;
      run_ctrl_s.if_id_wr = 1'b0;
      run_ctrl_s.id_flush = 1'b1;
    end else if (icache_stall) begin
      run_ctrl_s.pc_wr    = 1'b0;
      run_ctrl_s.if_id_wr = 1'b0;
      run_ctrl_s.if_flush = 1'b1;
    end else begin
      run_ctrl_s = CTRL_NORMAL;
    end
  end

  // Next state and stage controls in priority order: post-reset, redirect,
  // dcache stall, then the per-state behaviour.
  always_comb begin
    ctrl_s    = CTRL_NORMAL;
    state_d   = state_q;
    cnt_d     = cnt_q;
    npc_lat_d = npc_lat_q;
    if (post_rst_q) begin
      // First cycle out of reset decodes as plain RUN whatever the inputs say.
      state_d   = ST_RUN;
      cnt_d     = {DIV_CNT_W{1'b0}};
      npc_lat_d = NPC_NORMAL;
    end else if (redirect_s && !dcache_stall) begin
      ctrl_s.if_flush  = 1'b1;
      ctrl_s.id_flush  = 1'b1;
      ctrl_s.ex_flush  = 1'b1;
      ctrl_s.mem_flush = 1'b1;
      ctrl_s.npc_sel   = redirect_npc(MEM_Exception);
      npc_lat_d        = redirect_npc(MEM_Exception);
      cnt_d            = {DIV_CNT_W{1'b0}};
      if (icache_stall) begin
        ctrl_s.pc_wr = 1'b0;
        state_d      = ST_REDIR;
      end else begin
        state_d      = ST_RUN;
      end
    end else if (dcache_stall) begin
      ctrl_s         = CTRL_FREEZE;
      ctrl_s.npc_sel = (state_q == ST_REDIR) ? npc_lat_q : NPC_NORMAL;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (EX_start) begin
            ctrl_s  = CTRL_DIV;
            state_d = ST_DIV;
            cnt_d   = DIV_CNT_LOAD;
          end else begin
            ctrl_s  = run_ctrl_s;
          end
        end
        ST_DIV: begin
          if (cnt_q == {DIV_CNT_W{1'b0}}) begin
            ctrl_s  = run_ctrl_s;
            state_d = ST_RUN;
          end else begin
            ctrl_s  = CTRL_DIV;
            cnt_d   = cnt_q - {{(DIV_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_REDIR: begin
          ctrl_s.if_flush = 1'b1;
          ctrl_s.id_flush = 1'b1;
          ctrl_s.ex_flush = 1'b1;
          ctrl_s.npc_sel  = npc_lat_q;
          if (icache_stall) begin
            ctrl_s.pc_wr = 1'b0;
          end else begin
            state_d      = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = {DIV_CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign PC_Wr       = ctrl_s.pc_wr;
  assign IF_IDWr     = ctrl_s.if_id_wr;
  assign ID_EX_WrEn  = ctrl_s.id_ex_wr;
  assign EX_MEM_WrEn = ctrl_s.ex_mem_wr;
  assign IF_Flush    = ctrl_s.if_flush;
  assign ID_Flush    = ctrl_s.id_flush;
  assign EX_Flush    = ctrl_s.ex_flush;
  assign MEM_Flush   = ctrl_s.mem_flush;
  assign NPC_Sel     = ctrl_s.npc_sel;
  assign div_busy    = div_busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected
// control vector; a monitor pops and compares mid-cycle.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic       icache_stall, dcache_stall;
  logic       EX_DMRd;
  logic [4:0] EX_RD, ID_RS, ID_RT;
  logic       ID_UseRS, ID_UseRT;
  logic       EX_start, MEM_Exception, MEM_eret_flush;
  logic       PC_Wr, IF_IDWr, ID_EX_WrEn, EX_MEM_WrEn;
  logic       IF_Flush, ID_Flush, EX_Flush, MEM_Flush;
  logic [1:0] NPC_Sel;
  logic       div_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [10:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  logic [10:0] obs;
  assign obs = {PC_Wr, IF_IDWr, ID_EX_WrEn, EX_MEM_WrEn,
                IF_Flush, ID_Flush, EX_Flush, MEM_Flush, NPC_Sel, div_busy};

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .EX_DMRd        (EX_DMRd),
    .EX_RD          (EX_RD),
    .ID_RS          (ID_RS),
    .ID_RT          (ID_RT),
    .ID_UseRS       (ID_UseRS),
    .ID_UseRT       (ID_UseRT),
    .EX_start       (EX_start),
    .MEM_Exception  (MEM_Exception),
    .MEM_eret_flush (MEM_eret_flush),
    .PC_Wr          (PC_Wr),
    .IF_IDWr        (IF_IDWr),
    .ID_EX_WrEn     (ID_EX_WrEn),
    .EX_MEM_WrEn    (EX_MEM_WrEn),
    .IF_Flush       (IF_Flush),
    .ID_Flush       (ID_Flush),
    .EX_Flush       (EX_Flush),
    .MEM_Flush      (MEM_Flush),
    .NPC_Sel        (NPC_Sel),
    .div_busy       (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {wr enables PC,IFID,IDEX,EXMEM}{flushes IF,ID,EX,MEM}{NPC_Sel}{div_busy}
  function automatic logic [10:0] mk(input logic [3:0] w, input logic [3:0] f,
                                     input logic [1:0] n, input logic b);
    return {w, f, n, b};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [10:0] exp);
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic clr();
    icache_stall = 1'b0; dcache_stall = 1'b0;
    EX_DMRd = 1'b0; EX_RD = 5'd0; ID_RS = 5'd0; ID_RT = 5'd0;
    ID_UseRS = 1'b0; ID_UseRT = 1'b0;
    EX_start = 1'b0; MEM_Exception = 1'b0; MEM_eret_flush = 1'b0;
  endtask

  // Monitor: compare the oldest expectation a few ns after inputs change.
  always begin
    @(negedge clk);
    #3;
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check_eq(sb_e.tag, {21'd0, obs}, {21'd0, sb_e.exp});
    end
  end

  localparam logic [10:0] NRM0 = {4'b1111, 4'b0000, 2'b00, 1'b0};
  localparam logic [10:0] NRM1 = {4'b1111, 4'b0000, 2'b00, 1'b1};
  localparam logic [10:0] LU   = {4'b0011, 4'b0100, 2'b00, 1'b0};
  localparam logic [10:0] IC   = {4'b0011, 4'b1000, 2'b00, 1'b0};
  localparam logic [10:0] DS0  = {4'b0000, 4'b0000, 2'b00, 1'b0};
  localparam logic [10:0] DS1  = {4'b0000, 4'b0000, 2'b00, 1'b1};
  localparam logic [10:0] DV0  = {4'b0000, 4'b0010, 2'b00, 1'b0};
  localparam logic [10:0] DV1  = {4'b0000, 4'b0010, 2'b00, 1'b1};

  initial begin
    clr();
    rst = 1'b0;
    icache_stall = 1'b1; MEM_Exception = 1'b1; EX_start = 1'b1;
    @(negedge clk);
    idle();
    rst = 1'b1;
    step("post_rst", NRM0);
    clr();
    step("run", NRM0);

    // Load-use hazards and non-hazards
    EX_DMRd = 1'b1; EX_RD = 5'd5; ID_RS = 5'd5; ID_UseRS = 1'b1;
    step("lu_rs", LU);
    clr();
    step("lu_after", NRM0);
    EX_DMRd = 1'b1; EX_RD = 5'd7; ID_RT = 5'd7; ID_UseRT = 1'b1; ID_RS = 5'd7;
    step("lu_rt", LU);
    clr();
    EX_DMRd = 1'b1; EX_RD = 5'd0; ID_RS = 5'd0; ID_UseRS = 1'b1;
    step("lu_r0", NRM0);
    EX_RD = 5'd9; ID_RS = 5'd9; ID_UseRS = 1'b0;
    step("lu_nouse", NRM0);
    clr();

    // Fetch stall, priority against load-use, data stall
    icache_stall = 1'b1;
    step("icache", IC);
    EX_DMRd = 1'b1; EX_RD = 5'd3; ID_RS = 5'd3; ID_UseRS = 1'b1;
    step("lu_over_ic", LU);
    clr();
    dcache_stall = 1'b1; icache_stall = 1'b1;
    step("dcache", DS0);
    MEM_Exception = 1'b1;
    step("dc_over_exc", DS0);
    clr();
    step("dc_after", NRM0);

    // Full divide
    EX_start = 1'b1;
    step("div_start", DV0);
    EX_start = 1'b0;
    for (int k = 1; k <= 31; k++) step("div_cnt", DV1);
    step("div_done", NRM1);
    step("div_idle", NRM0);

    // Divide with three dcache stalls mid-count
    EX_start = 1'b1;
    step("divd_start", DV0);
    EX_start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k >= 11 && k <= 13) begin
        dcache_stall = 1'b1;
        step("divd_dstall", DS1);
      end else begin
        dcache_stall = 1'b0;
        step("divd_cnt", DV1);
      end
    end
    dcache_stall = 1'b0;
    step("divd_done", NRM1);
    step("divd_idle", NRM0);

    // ERET aborts a divide at count 10
    EX_start = 1'b1;
    step("dive_start", DV0);
    EX_start = 1'b0;
    for (int k = 1; k <= 21; k++) step("dive_cnt", DV1);
    MEM_eret_flush = 1'b1;
    step("eret_div", mk(4'b1111, 4'b1111, 2'b11, 1'b1));
    MEM_eret_flush = 1'b0;
    step("eret_after", NRM0);

    // Exception held off by four fetch-stall cycles
    MEM_Exception = 1'b1; icache_stall = 1'b1;
    step("exc_ic0", mk(4'b0111, 4'b1111, 2'b10, 1'b0));
    MEM_Exception = 1'b0;
    for (int k = 1; k <= 3; k++) step("exc_redir", mk(4'b0111, 4'b1110, 2'b10, 1'b0));
    icache_stall = 1'b0;
    step("exc_release", mk(4'b1111, 4'b1110, 2'b10, 1'b0));
    step("exc_after", NRM0);

    // Exception and ERET together; exception wins
    MEM_Exception = 1'b1; MEM_eret_flush = 1'b1;
    step("exc_eret", mk(4'b1111, 4'b1111, 2'b10, 1'b0));
    clr();
    step("exc_eret_after", NRM0);

    // New redirect inside REDIR re-latches the target
    MEM_eret_flush = 1'b1; icache_stall = 1'b1;
    step("eret_ic", mk(4'b0111, 4'b1111, 2'b11, 1'b0));
    MEM_eret_flush = 1'b0; MEM_Exception = 1'b1;
    step("relatch", mk(4'b0111, 4'b1111, 2'b10, 1'b0));
    MEM_Exception = 1'b0;
    step("relatch_hold", mk(4'b0111, 4'b1110, 2'b10, 1'b0));
    icache_stall = 1'b0;
    step("relatch_rel", mk(4'b1111, 4'b1110, 2'b10, 1'b0));
    step("relatch_after", NRM0);

    // Reset abandons a divide
    EX_start = 1'b1;
    step("divr_start", DV0);
    EX_start = 1'b0;
    for (int k = 1; k <= 5; k++) step("divr_cnt", DV1);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    step("rst_div", NRM0);
    step("rst_div_after", NRM0);

    // Reset abandons a REDIR
    MEM_Exception = 1'b1; icache_stall = 1'b1;
    step("redir_enter", mk(4'b0111, 4'b1111, 2'b10, 1'b0));
    MEM_Exception = 1'b0;
    step("redir_hold", mk(4'b0111, 4'b1110, 2'b10, 1'b0));
    rst = 1'b0;
    idle();
    rst = 1'b1;
    step("rst_redir", NRM0);
    icache_stall = 1'b0;
    step("rst_redir_after", NRM0);

    #5;
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
